// File: rtl/alu_ctrl_md_if.sv
// alu_ctrl_md_if: decode request, operands and HI/LO results between EX
// control and the ALU control / multiply-divide block.
interface alu_ctrl_md_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       ALUOP;
    logic [5:0]       funct;
    logic             op_valid;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [3:0]       OP;
    logic             illegal;
    logic             md_stall;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output ALUOP, funct, op_valid, rs_val, rt_val,
        input  OP, illegal, md_stall, md_done, hi, lo
    );

    modport slave (
        input  ALUOP, funct, op_valid, rs_val, rt_val,
        output OP, illegal, md_stall, md_done, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: EX-stage ALU control decoder plus iterative mul/div with HI/LO.
// Define MULDIV_EN to build the sequencer, HI/LO and mfhi/mflo/mult/div decode.
module alu_ctrl_md #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_ctrl_md_if.slave bus
);
    logic [3:0] op;
    logic       ill;

    always_comb begin
        op  = 4'd15;
        ill = 1'b0;
        unique case (bus.ALUOP)
            2'd0: op = 4'd2;
            2'd1: op = 4'd3;
            2'd2: begin
                case (bus.funct)
                    6'd36: op = 4'd0;
                    6'd37: op = 4'd1;
                    6'd32: op = 4'd2;
                    6'd34: op = 4'd3;
                    6'd0:  op = 4'd4;
                    6'd42: op = 4'd5;
                    6'd2:  op = 4'd6;
                    6'd39: op = 4'd7;
                    6'd38: op = 4'd8;
                    6'd43: op = 4'd9;
`ifdef MULDIV_EN
                    6'd16: op = 4'd10;
                    6'd18: op = 4'd11;
                    6'd24, 6'd25, 6'd26, 6'd27: op = 4'd15;
`endif
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

    assign bus.OP      = op;
    assign bus.illegal = ill;

`ifdef MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   m;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               md_req;
    logic               hilo_rd;
    logic               busy;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     t;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign md_req  = bus.op_valid && bus.ALUOP == 2'd2
                     && bus.funct[5:2] == 4'b0110;
    assign hilo_rd = bus.op_valid && bus.ALUOP == 2'd2
                     && (bus.funct == 6'd16 || bus.funct == 6'd18);
    assign busy    = state != IDLE;
    assign sgn     = !bus.funct[0];
    assign abs_a   = (sgn && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    assign abs_b   = (sgn && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

    // acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        t   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        if (!is_div) begin
            step = {sum, acc[WIDTH-1:1]};
        end else if (t >= {1'b0, m}) begin
            step = {t[WIDTH-1:0] - m, acc[WIDTH-2:0], 1'b1};
        end else begin
            step = {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // divide by zero keeps an all-ones quotient regardless of sign
    assign prod = neg_q ? -acc : acc;
    assign quo  = (neg_q && m != '0) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (md_req) begin
                        is_div <= bus.funct[1];
                        neg_q  <= sgn && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        neg_r  <= sgn && bus.rs_val[WIDTH-1];
                        m      <= bus.funct[1] ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, bus.funct[1] ? abs_a : abs_b};
                        cnt    <= CW'(WIDTH - 1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= step;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.md_stall = busy && (md_req || hilo_rd);
    assign bus.md_done  = done;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
`else
    logic unused;
    assign unused = ^{clk, rst_n, bus.op_valid, bus.rs_val, bus.rt_val};

    assign bus.md_stall = 1'b0;
    assign bus.md_done  = 1'b0;
    assign bus.hi       = '0;
    assign bus.lo       = '0;
`endif
endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: decode sweep, directed and random mul/div against a
// behavioural arithmetic model, stall/overlap, back-to-back and abort.
`timescale 1ns/1ps
module tb_alu_ctrl_md;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_md_if #(.WIDTH(W)) bus();

    alu_ctrl_md #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.ALUOP    = aop;
        bus.funct    = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
    endtask

    // returns {illegal, OP}
    function automatic logic [4:0] ref_dec(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'd0) return {1'b0, 4'd2};
        if (aop == 2'd1) return {1'b0, 4'd3};
        if (aop == 2'd3) return {1'b1, 4'd15};
        case (f)
            6'd36: return {1'b0, 4'd0};
            6'd37: return {1'b0, 4'd1};
            6'd32: return {1'b0, 4'd2};
            6'd34: return {1'b0, 4'd3};
            6'd0:  return {1'b0, 4'd4};
            6'd42: return {1'b0, 4'd5};
            6'd2:  return {1'b0, 4'd6};
            6'd39: return {1'b0, 4'd7};
            6'd38: return {1'b0, 4'd8};
            6'd43: return {1'b0, 4'd9};
`ifdef MULDIV_EN
            6'd16: return {1'b0, 4'd10};
            6'd18: return {1'b0, 4'd11};
            6'd24, 6'd25, 6'd26, 6'd27: return {1'b0, 4'd15};
`endif
            default: return {1'b1, 4'd15};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 6'd24, 32'd7, 32'd9);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 6'd18, 32'd0, 32'd0);
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h_%h exp 0_0", bus.hi, bus.lo);
        end
        checks++;
        if (bus.md_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b exp 0", bus.md_done);
        end
        checks++;
        if (bus.md_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b exp 0", bus.md_stall);
        end
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_decode();
        logic [5:0] fl [16];
        logic [4:0] exp_v;
        fl = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd0, 6'd42, 6'd2, 6'd39,
               6'd38, 6'd43, 6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27};
        for (int i = 0; i < 60; i++) begin
            logic [1:0] aop;
            logic [5:0] f;
            if (i < 16) begin
                aop = 2'd2;
                f   = fl[i];
            end else if (i == 16) begin
                aop = 2'd2;
                f   = 6'd5;
            end else if (i < 20) begin
                aop = (i == 17) ? 2'd0 : (i == 18) ? 2'd1 : 2'd3;
                f   = 6'($urandom);
            end else begin
                aop = 2'($urandom);
                f   = 6'($urandom);
            end
            drive(1'b0, aop, f, $urandom, $urandom);
            #1;
            exp_v = ref_dec(aop, f);
            checks++;
            if ({bus.illegal, bus.OP} !== exp_v) begin
                errors++;
                $display("FAIL decode aluop=%0d funct=%0d got ill=%b op=%0d exp ill=%b op=%0d",
                         aop, f, bus.illegal, bus.OP, exp_v[4], exp_v[3:0]);
            end
        end
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    endtask

`ifdef MULDIV_EN
    task automatic ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
        longint     sa;
        longint     sb;
        longint     q;
        longint     r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'd24: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            6'd25: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            6'd26: begin
                if (b == 32'd0) begin
                    h = a;
                    l = '1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = '1;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        drive(1'b1, 2'd2, f, a, b);
        #1;
        checks++;
        if (bus.md_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s accept_stall got %b exp 0", name, bus.md_stall);
        end
        tick();
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        n = 0;
        while (bus.md_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != W + 1) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", name, n + 1, W + 2);
        end
        checks++;
        if (bus.hi !== eh || bus.lo !== el) begin
            errors++;
            $display("FAIL %s hilo got %h_%h exp %h_%h", name, bus.hi, bus.lo, eh, el);
        end
        tick();
        checks++;
        if (bus.md_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse got %b exp 0", name, bus.md_done);
        end
    endtask

    task automatic test_mul_div();
        run_op("mult_neg3x5", 6'd24, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("divu_100_7", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_neg7_2", 6'd26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2", 6'd26, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("div_5_0", 6'd26, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        run_op("div_neg9_0", 6'd26, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
        run_op("divu_x_0", 6'd27, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("div_min_m1", 6'd26, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("multu_max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    endtask

    task automatic test_overlap();
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        ref_md(6'd24, 32'd123456, 32'hFFFFF000, eh, el);
        drive(1'b1, 2'd2, 6'd24, 32'd123456, 32'hFFFFF000);
        tick();
        drive(1'b1, 2'd2, 6'd32, 32'd1, 32'd2);
        #1;
        checks++;
        if (bus.md_stall !== 1'b0 || bus.OP !== 4'd2) begin
            errors++;
            $display("FAIL overlap_add got stall=%b op=%0d exp stall=0 op=2", bus.md_stall, bus.OP);
        end
        tick();
        drive(1'b1, 2'd2, 6'd18, 32'd0, 32'd0);
        #1;
        n = 0;
        while (bus.md_stall === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != W) begin
            errors++;
            $display("FAIL mflo_stall_cycles got %0d exp %0d", n, W);
        end
        checks++;
        if (bus.md_done !== 1'b1 || bus.lo !== el || bus.OP !== 4'd11) begin
            errors++;
            $display("FAIL mflo_release got done=%b lo=%h op=%0d exp done=1 lo=%h op=11",
                     bus.md_done, bus.lo, bus.OP, el);
        end
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] h1;
        logic [31:0] l1;
        logic [31:0] h2;
        logic [31:0] l2;
        int          n;
        ref_md(6'd25, 32'hDEADBEEF, 32'h12345678, h1, l1);
        ref_md(6'd25, 32'h0000FFFF, 32'hCAFEF00D, h2, l2);
        drive(1'b1, 2'd2, 6'd25, 32'hDEADBEEF, 32'h12345678);
        tick();
        drive(1'b1, 2'd2, 6'd25, 32'h0000FFFF, 32'hCAFEF00D);
        #1;
        n = 0;
        while (bus.md_stall === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != W + 1) begin
            errors++;
            $display("FAIL b2b_stall_cycles got %0d exp %0d", n, W + 1);
        end
        checks++;
        if (bus.md_done !== 1'b1 || bus.hi !== h1 || bus.lo !== l1) begin
            errors++;
            $display("FAIL b2b_first got done=%b %h_%h exp done=1 %h_%h",
                     bus.md_done, bus.hi, bus.lo, h1, l1);
        end
        tick();
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        n = 0;
        while (bus.md_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != W + 1) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d exp %0d", n + 1, W + 2);
        end
        checks++;
        if (bus.hi !== h2 || bus.lo !== l2) begin
            errors++;
            $display("FAIL b2b_second got %h_%h exp %h_%h", bus.hi, bus.lo, h2, l2);
        end
        tick();
    endtask

    task automatic test_no_valid();
        int bad;
        bad = 0;
        drive(1'b0, 2'd2, 6'd24, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.md_stall !== 1'b0) bad++;
        end
        drive(1'b1, 2'd2, 6'd16, 32'd0, 32'd0);
        #1;
        if (bus.md_stall !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_valid_stall got %0d stalled cycles exp 0", bad);
        end
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_abort();
        int seen;
        run_op("div_pre_abort", 6'd26, 32'd1000, 32'd3, 32'd1, 32'd333);
        drive(1'b1, 2'd2, 6'd26, 32'd77777, 32'd5);
        tick();
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 6'd24, 32'd9, 32'd9);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.md_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear got %h_%h done=%b exp 0_0 done=0",
                     bus.hi, bus.lo, bus.md_done);
        end
        drive(1'b1, 2'd2, 6'd18, 32'd0, 32'd0);
        #1;
        checks++;
        if (bus.md_stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_stall got %b exp 0", bus.md_stall);
        end
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.md_done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses exp 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        for (int i = 0; i < 14; i++) begin
            f = 6'(24 + $urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFFFFFF;
                3: a = 32'h80000000;
                default: ;
            endcase
            ref_md(f, a, b, eh, el);
            run_op("random", f, a, b, eh, el);
        end
    endtask
`else
    task automatic test_disabled();
        int bad;
        bad = 0;
        drive(1'b1, 2'd2, 6'd24, 32'hFFFFFFFD, 32'd5);
        for (int i = 0; i < 40; i++) begin
            if (i == 20) drive(1'b1, 2'd2, 6'd18, 32'd0, 32'd0);
            tick();
            if (bus.illegal !== 1'b1 || bus.md_stall !== 1'b0 || bus.md_done !== 1'b0
                || bus.hi !== 32'd0 || bus.lo !== 32'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL disabled_md got %0d bad cycles exp 0", bad);
        end
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
        test_reset();
        test_decode();
`ifdef MULDIV_EN
        test_mul_div();
        test_overlap();
        test_back_to_back();
        test_no_valid();
        test_abort();
        test_random();
`else
        test_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
